cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/lc3b_types.sv | 33 +++
 rtl/arbiter_timeout_counter.sv | 36 +++
 rtl/cache_arbiter.sv | 139 +++++++++++++
 tb/tb_cache_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: line/word/mask widths, pmem request payload and arbiter state.
package lc3b_types;

  localparam int unsigned LINE_W = 128;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned MASK_W = 16;
  localparam int unsigned CNT_W  = 16;

  typedef logic [LINE_W-1:0] lc3b_data;
  typedef logic [WORD_W-1:0] lc3b_word;
  typedef logic [MASK_W-1:0] lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } lc3b_arb_state;

  typedef enum logic {
    CLIENT_I = 1'b0,
    CLIENT_D = 1'b1
  } lc3b_arb_client;

  typedef struct packed {
    lc3b_word      address;
    lc3b_data      wdata;
    logic          cyc;
    logic          stb;
    logic          write;
    lc3b_mem_wmask byte_enable;
  } lc3b_mem_req;

endpackage

// File: rtl/arbiter_timeout_counter.sv
// Saturating wait counter for a granted transaction; flags when LIMIT cycles have elapsed.
module arbiter_timeout_counter
  import lc3b_types::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q >= CNT_W'(LIMIT));

endmodule

// File: rtl/cache_arbiter.sv
// Two-client (I-cache / D-cache) arbiter onto a single pmem port with alternating tie-break and timeout.
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,

  input  lc3b_word      icache_address,
  input  logic          icache_cyc,
  input  logic          icache_stb,
  output lc3b_data      icache_rdata,
  output logic          icache_resp,
  output logic          icache_retry,

  input  lc3b_word      dcache_address,
  input  lc3b_data      dcache_wdata,
  input  logic          dcache_cyc,
  input  logic          dcache_stb,
  input  logic          dcache_write,
  input  lc3b_mem_wmask dcache_byte_enable,
  output lc3b_data      dcache_rdata,
  output logic          dcache_resp,
  output logic          dcache_retry,

  output lc3b_word      pmem_address,
  output lc3b_data      pmem_wdata,
  output logic          pmem_cyc,
  output logic          pmem_stb,
  output logic          pmem_write,
  output lc3b_mem_wmask pmem_byte_enable,
  input  lc3b_data      pmem_rdata,
  input  logic          pmem_resp,
  input  logic          pmem_retry
);

  lc3b_arb_state  state_q, state_d;
  lc3b_arb_client last_grant_q, last_grant_d;

  lc3b_mem_req i_req;
  lc3b_mem_req d_req;
  lc3b_mem_req pmem_req;

  logic i_pend, d_pend;
  logic is_d;
  logic resp_c, retry_c;
  logic cnt_clear, cnt_enable, cnt_expired;

  assign i_pend = icache_cyc & icache_stb;
  assign d_pend = dcache_cyc & dcache_stb;
  assign is_d   = (state_q == GRANT_D);

  // The I side is read-only, so its write payload is tied off.
  assign i_req = '{address: icache_address, wdata: '0, cyc: icache_cyc, stb: icache_stb,
                   write: 1'b0, byte_enable: '0};
  assign d_req = '{address: dcache_address, wdata: dcache_wdata, cyc: dcache_cyc,
                   stb: dcache_stb, write: dcache_write, byte_enable: dcache_byte_enable};

  arbiter_timeout_counter #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(cnt_expired)
  );

  // Next-state, grant mux and return routing.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pmem_req     = '0;
    resp_c       = 1'b0;
    retry_c      = 1'b0;
    cnt_clear    = 1'b0;
    cnt_enable   = 1'b0;

    if (state_q == IDLE) begin
      cnt_clear = 1'b1;
      if (i_pend && d_pend) begin
        state_d = (last_grant_q == CLIENT_I) ? GRANT_D : GRANT_I;
      end else if (d_pend) begin
        state_d = GRANT_D;
      end else if (i_pend) begin
        state_d = GRANT_I;
      end
    end else begin
      pmem_req = is_d ? d_req : i_req;
      if (!pmem_req.cyc) begin
        // Client abandoned the transaction: nothing is returned to it.
        state_d = IDLE;
      end else if (cnt_expired) begin
        pmem_req.cyc = 1'b0;
        pmem_req.stb = 1'b0;
        retry_c      = 1'b1;
        state_d      = IDLE;
        last_grant_d = is_d ? CLIENT_D : CLIENT_I;
      end else if (pmem_resp) begin
        resp_c       = 1'b1;
        state_d      = IDLE;
        last_grant_d = is_d ? CLIENT_D : CLIENT_I;
      end else if (pmem_retry) begin
        retry_c      = 1'b1;
        state_d      = IDLE;
        last_grant_d = is_d ? CLIENT_D : CLIENT_I;
      end else begin
        cnt_enable = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= CLIENT_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign pmem_address     = pmem_req.address;
  assign pmem_wdata       = pmem_req.wdata;
  assign pmem_cyc         = pmem_req.cyc;
  assign pmem_stb         = pmem_req.stb;
  assign pmem_write       = pmem_req.write;
  assign pmem_byte_enable = pmem_req.byte_enable;

  assign icache_rdata = pmem_rdata;
  assign dcache_rdata = pmem_rdata;

  assign icache_resp  = resp_c  & (state_q == GRANT_I);
  assign icache_retry = retry_c & (state_q == GRANT_I);
  assign dcache_resp  = resp_c  & is_d;
  assign dcache_retry = retry_c & is_d;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios then random traffic against a transaction model.
module tb_cache_arbiter;
  import lc3b_types::*;

  localparam int unsigned TO = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  icache_address, dcache_address, pmem_address;
  logic         icache_cyc, icache_stb, icache_resp, icache_retry;
  logic [127:0] icache_rdata, dcache_rdata, dcache_wdata, pmem_wdata, pmem_rdata;
  logic         dcache_cyc, dcache_stb, dcache_write, dcache_resp, dcache_retry;
  logic [15:0]  dcache_byte_enable, pmem_byte_enable;
  logic         pmem_cyc, pmem_stb, pmem_write, pmem_resp, pmem_retry;

  cache_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .icache_address(icache_address), .icache_cyc(icache_cyc), .icache_stb(icache_stb),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp), .icache_retry(icache_retry),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata), .dcache_cyc(dcache_cyc),
    .dcache_stb(dcache_stb), .dcache_write(dcache_write), .dcache_byte_enable(dcache_byte_enable),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp), .dcache_retry(dcache_retry),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_cyc(pmem_cyc),
    .pmem_stb(pmem_stb), .pmem_write(pmem_write), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .pmem_retry(pmem_retry)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  // Transaction model: who owns pmem (0 none, 1 I, 2 D), cycles waited, who was served last.
  int owner     = 0;
  int waited    = 0;
  bit last_was_d = 1'b0;

  logic obs_pcyc, obs_i_resp, obs_i_retry, obs_d_resp, obs_d_retry;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    icache_cyc = 1'b0; icache_stb = 1'b0; dcache_cyc = 1'b0; dcache_stb = 1'b0;
    dcache_write = 1'b0; pmem_resp = 1'b0; pmem_retry = 1'b0;
  endtask

  task automatic model_reset();
    owner = 0; waited = 0; last_was_d = 1'b0;
  endtask

  // Check one cycle's combinational outputs against the model, then advance one clock.
  task automatic tick();
    logic [15:0]  e_addr, e_be;
    logic [127:0] e_wdata;
    logic         e_cyc, e_stb, e_write, e_resp, e_retry, c_cyc;
    int           n_owner, n_waited;
    bit           n_last;
    #2;
    e_addr = '0; e_be = '0; e_wdata = '0;
    e_cyc = 1'b0; e_stb = 1'b0; e_write = 1'b0; e_resp = 1'b0; e_retry = 1'b0;
    n_owner = owner; n_waited = waited; n_last = last_was_d;
    if (owner == 0) begin
      n_waited = 0;
      if ((icache_cyc && icache_stb) && (dcache_cyc && dcache_stb)) n_owner = last_was_d ? 1 : 2;
      else if (dcache_cyc && dcache_stb) n_owner = 2;
      else if (icache_cyc && icache_stb) n_owner = 1;
    end else begin
      if (owner == 2) begin
        e_addr = dcache_address; e_wdata = dcache_wdata; e_write = dcache_write;
        e_be = dcache_byte_enable; c_cyc = dcache_cyc; e_stb = dcache_stb;
      end else begin
        e_addr = icache_address; c_cyc = icache_cyc; e_stb = icache_stb;
      end
      e_cyc = c_cyc;
      if (!c_cyc) begin
        n_owner = 0;
      end else if (waited >= int'(TO)) begin
        e_cyc = 1'b0; e_stb = 1'b0; e_retry = 1'b1; n_owner = 0; n_last = (owner == 2);
      end else if (pmem_resp || pmem_retry) begin
        e_resp = pmem_resp; e_retry = !pmem_resp; n_owner = 0; n_last = (owner == 2);
      end else begin
        n_waited = waited + 1;
      end
    end
    obs_pcyc = pmem_cyc; obs_i_resp = icache_resp; obs_i_retry = icache_retry;
    obs_d_resp = dcache_resp; obs_d_retry = dcache_retry;
    chk("pmem_cyc", 128'(pmem_cyc), 128'(e_cyc));
    chk("pmem_stb", 128'(pmem_stb), 128'(e_stb));
    chk("pmem_address", 128'(pmem_address), 128'(e_addr));
    chk("pmem_wdata", pmem_wdata, e_wdata);
    chk("pmem_write", 128'(pmem_write), 128'(e_write));
    chk("pmem_byte_enable", 128'(pmem_byte_enable), 128'(e_be));
    chk("icache_resp", 128'(icache_resp), 128'(e_resp && owner == 1));
    chk("icache_retry", 128'(icache_retry), 128'(e_retry && owner == 1));
    chk("dcache_resp", 128'(dcache_resp), 128'(e_resp && owner == 2));
    chk("dcache_retry", 128'(dcache_retry), 128'(e_retry && owner == 2));
    chk("rdata", {icache_rdata ^ pmem_rdata} | {dcache_rdata ^ pmem_rdata}, 128'(0));
    @(posedge clk);
    #1;
    owner = n_owner; waited = n_waited; last_was_d = n_last;
  endtask

  initial begin
    int cnt_a, cnt_b, waits;
    bit done;

    // Reset state, with requests and a stray pmem_resp present.
    rst = 1'b1;
    idle_inputs();
    icache_address = 16'h1234; dcache_address = 16'h4321; dcache_wdata = '1;
    dcache_byte_enable = 16'hFFFF; pmem_rdata = {4{32'hDEADBEEF}};
    icache_cyc = 1'b1; icache_stb = 1'b1; dcache_cyc = 1'b1; dcache_stb = 1'b1;
    pmem_resp = 1'b1; pmem_retry = 1'b1;
    #3;
    chk("rst_pmem_cyc", 128'(pmem_cyc), 128'(0));
    chk("rst_pmem_address", 128'(pmem_address), 128'(0));
    chk("rst_resp_retry", 128'({icache_resp, icache_retry, dcache_resp, dcache_retry}), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    model_reset();

    // I-only read at 0x1000 answered in the third granted cycle.
    icache_address = 16'h1000; icache_cyc = 1'b1; icache_stb = 1'b1;
    tick();
    chk("i_latency_cyc0", 128'(obs_pcyc), 128'(0));
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 3; k++) begin
      pmem_resp = (k == 2);
      #2 chk("i_addr_granted", 128'(pmem_address), 128'(16'h1000));
      #0 tick();
      cnt_a += int'(obs_i_resp); cnt_b += int'(obs_d_resp);
    end
    idle_inputs();
    tick();
    chk("i_resp_pulses", 128'(cnt_a), 128'(1));
    chk("d_resp_quiet", 128'(cnt_b), 128'(0));

    // Tie after reset goes to D; then I; a repeated tie goes to D again.
    model_reset();
    rst = 1'b1; #1 rst = 1'b0;
    icache_address = 16'h0A00; dcache_address = 16'h0D00;
    icache_cyc = 1'b1; icache_stb = 1'b1; dcache_cyc = 1'b1; dcache_stb = 1'b1;
    tick();
    #2 chk("tie1_grant_d", 128'(pmem_address), 128'(16'h0D00));
    pmem_resp = 1'b1; tick();
    pmem_resp = 1'b0; dcache_cyc = 1'b0; dcache_stb = 1'b0;
    tick();
    #2 chk("then_grant_i", 128'(pmem_address), 128'(16'h0A00));
    pmem_resp = 1'b1; tick();
    pmem_resp = 1'b0; dcache_cyc = 1'b1; dcache_stb = 1'b1;
    tick();
    #2 chk("tie2_grant_d", 128'(pmem_address), 128'(16'h0D00));
    pmem_resp = 1'b1; tick();
    idle_inputs(); tick();

    // D write answered by retry, then re-requested.
    dcache_address = 16'h2000; dcache_wdata = {16{8'hA5}}; dcache_byte_enable = 16'h000F;
    dcache_cyc = 1'b1; dcache_stb = 1'b1; dcache_write = 1'b1;
    tick();
    pmem_retry = 1'b1; tick();
    chk("d_retry_seen", 128'(obs_d_retry), 128'(1));
    pmem_retry = 1'b0; tick();
    chk("d_retry_one_cycle", 128'({obs_d_retry, obs_pcyc}), 128'(0));
    #2 chk("d_regranted", 128'({pmem_cyc, pmem_write, pmem_byte_enable}), 128'({2'b11, 16'h000F}));
    pmem_resp = 1'b1; tick();
    idle_inputs(); tick();

    // Silent pmem: exactly TO wait cycles, then icache_retry with pmem_cyc low.
    icache_address = 16'h3000; icache_cyc = 1'b1; icache_stb = 1'b1;
    tick();
    waits = 0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      if (obs_i_retry) done = 1'b1;
      else if (obs_pcyc) waits++;
    end
    chk("timeout_reached", 128'(done), 128'(1));
    chk("timeout_waits", 128'(waits), 128'(TO));
    chk("timeout_pcyc", 128'(obs_pcyc), 128'(0));
    idle_inputs(); tick();

    // Reset mid GRANT_D, then a late pmem_resp.
    dcache_address = 16'h4000; dcache_cyc = 1'b1; dcache_stb = 1'b1;
    tick(); tick();
    #2 chk("pre_rst_pcyc", 128'(pmem_cyc), 128'(1));
    pmem_resp = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_drops_pcyc", 128'(pmem_cyc), 128'(0));
    chk("rst_no_dresp", 128'(dcache_resp), 128'(0));
    chk("rst_state_idle", 128'(dut.state_q), 128'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0; dcache_cyc = 1'b0; dcache_stb = 1'b0;
    model_reset();
    tick(); tick();
    idle_inputs(); tick();

    // resp and retry together: resp wins.
    icache_address = 16'h5000; icache_cyc = 1'b1; icache_stb = 1'b1;
    tick();
    pmem_resp = 1'b1; pmem_retry = 1'b1; tick();
    chk("both_i_resp", 128'(obs_i_resp), 128'(1));
    chk("both_i_retry", 128'(obs_i_retry), 128'(0));
    idle_inputs(); tick();

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      icache_cyc = ($urandom_range(0, 4) != 0); icache_stb = ($urandom_range(0, 3) != 0);
      dcache_cyc = ($urandom_range(0, 4) != 0); dcache_stb = ($urandom_range(0, 3) != 0);
      dcache_write = 1'($urandom);
      icache_address = 16'($urandom); dcache_address = 16'($urandom);
      dcache_byte_enable = 16'($urandom);
      dcache_wdata = {$urandom, $urandom, $urandom, $urandom};
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      pmem_resp = ($urandom_range(0, 6) == 0); pmem_retry = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
